regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the RISC-V core, successor to the fixed 32x32, 2-read/1-write file.
- Adds a configurable XLEN, register count and read-port count, asynchronous clear, optional write-to-read bypass, and a per-register busy scoreboard.
- The scoreboard lets a pipelined decode stage stall on registers with pending writeback.
- Sits between decode (read and reserve) and writeback (write and release).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, register count, power of two, at least 2; register 0 is hardwired to zero.
- NREAD, 2, number of independent read ports, 1 to 4.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads see pre-write contents.
- AW is derived, not a parameter: AW = clog2(NREGS).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- read_address  input  NREAD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- read_value  output  NREAD*XLEN  packed read data, combinational.
- read_busy  output  NREAD  per-port flag: the addressed register has a pending write.
- write_enable  input  1  commit write_value to write_address at the clock edge.
- write_address  input  AW  writeback destination.
- write_value  input  XLEN  writeback data.
- reserve_enable  input  1  mark reserve_address busy (instruction issued).
- reserve_address  input  AW  destination being reserved.
- any_busy  output  1  OR of all busy bits, used for drain and fence.

Behaviour:
- Storage:
  - Registers 1..NREGS-1 are flops.
  - Register 0 always reads 0 and is never busy.
  - Writes and reserves addressed to 0 are ignored.
- Reset:
  - On reset_n low, immediately (asynchronously) clear all registers to 0 and all busy bits to 0.
  - read_value therefore reads 0 on every port, read_busy is 0 and any_busy is 0.
  - Reset asserted mid-operation discards any in-flight write or reserve in that cycle.
  - Release is synchronous to clock: the first edge with reset_n high performs normal updates.
- Write:
  - At the rising edge with write_enable=1 and write_address!=0, r[write_address] <= write_value.
  - The same edge clears busy[write_address].
- Reserve:
  - At the rising edge with reserve_enable=1 and reserve_address!=0, busy[reserve_address] <= 1.
  - Reserving a register that is already busy leaves it busy (idempotent; no count is kept).
- Write and reserve to the same address at the same edge:
  - The data is written.
  - Busy ends at 1, because the reserve belongs to a newer instruction and wins.
- Write and reserve to different addresses: both take effect independently.
- Reads are combinational, with no latency, and the NREAD ports are fully independent.
  - Address 0 gives read_value=0 and read_busy=0.
  - Otherwise, if BYPASS=1, write_enable=1 and read_address==write_address: read_value=write_value and read_busy=0.
  - A reserve in the same cycle does not affect that cycle's read_busy.
  - Otherwise read_value=r[addr] and read_busy=busy[addr].
- any_busy is combinational from the registered busy bits only; no bypass applies.
- Read addresses are never out of range, because NREGS is a power of two.
- Simulation assertion (non-synthesised): flag any write_enable to a register that is not busy. This is a warning only; the write still proceeds.

Test Plan:
- Reset and zero register:
  - Stimulus: assert reset_n=0 after filling r5=0xDEADBEEF; then write x0=0x12345678.
  - Response: all reads are 0 while reset is low. After release, reading x0 returns 0 and read_busy[0]=0.
- Write then read, BYPASS=1:
  - Stimulus: write x7=0xCAFEF00D; port 1 reads x7 in the same cycle.
  - Response: 0xCAFEF00D is returned in the same cycle. With BYPASS=0 the same cycle returns the old value 0, and the following cycle returns 0xCAFEF00D.
- Scoreboard lifecycle:
  - Stimulus: reserve x3; the next cycle write x3=0x55.
  - Response: read_busy=1 and any_busy=1 in the cycle after the reserve. Both return to 0 after the write edge, and the read returns 0x55.
- Simultaneous write and reserve:
  - Stimulus: with x9 busy, write x9=0xA5A5A5A5 and reserve x9 at the same edge.
  - Response: x9 reads 0xA5A5A5A5 with read_busy=1.
- Multi-port and parametrisation:
  - Stimulus: NREAD=3, XLEN=64, NREGS=16; write x1=1, x2=2, x15=0xFFFFFFFFFFFFFFFF; read x15, x0 and x2 on ports 0, 1 and 2 simultaneously.
  - Response: ports return 0xFFFFFFFFFFFFFFFF, 0 and 2 respectively.
- Reset mid-operation:
  - Stimulus: reserve x4 and x6; pulse reset_n low between clock edges.
  - Response: any_busy drops to 0 without waiting for a clock edge, and all registers read 0.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle between the decode/writeback side and the register file:
// read ports, writeback port, reserve port and the aggregate busy flag.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NREAD*AW-1:0]   read_address;
    logic [NREAD*XLEN-1:0] read_value;
    logic [NREAD-1:0]      read_busy;
    logic                  write_enable;
    logic [AW-1:0]         write_address;
    logic [XLEN-1:0]       write_value;
    logic                  reserve_enable;
    logic [AW-1:0]         reserve_address;
    logic                  any_busy;

    // Pipeline side: issues reads, reserves and writebacks.
    modport master (
        output read_address,
        output write_enable,
        output write_address,
        output write_value,
        output reserve_enable,
        output reserve_address,
        input  read_value,
        input  read_busy,
        input  any_busy
    );

    // Register file side.
    modport slave (
        input  read_address,
        input  write_enable,
        input  write_address,
        input  write_value,
        input  reserve_enable,
        input  reserve_address,
        output read_value,
        output read_busy,
        output any_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with a per-register busy scoreboard.
// x0 is hardwired to zero and never busy. Reads are combinational with an
// optional same-cycle write bypass; writes release a register, reserves mark
// it busy, and a reserve wins over a write to the same register.

// Warns when writeback targets a register that has no pending reservation.
module regfile_scoreboard_chk #(
    parameter int NREGS = 32
) (
    input logic                     clock,
    input logic                     reset_n,
    input logic                     write_enable,
    input logic [$clog2(NREGS)-1:0] write_address,
    input logic [NREGS-1:0]         busy
);
    localparam int AW = $clog2(NREGS);

    a_write_to_busy: assert property (
        @(posedge clock) disable iff (!reset_n)
        (write_enable && (write_address != {AW{1'b0}})) |-> busy[write_address]
    ) else $warning("regfile_scoreboard: write to non-busy register x%0d", write_address);
endmodule

module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input logic                 clock,
    input logic                 reset_n,
    regfile_scoreboard_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [XLEN-1:0]       regs_d [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic                  write_hit_s;
    logic                  reserve_hit_s;
    logic [AW-1:0]         port_addr_s [NREAD];
    logic [NREAD*XLEN-1:0] read_value_s;
    logic [NREAD-1:0]      read_busy_s;

    // Writes and reserves to x0 are dropped here so x0 stays zero and idle.
    assign write_hit_s   = bus.write_enable   && (bus.write_address   != {AW{1'b0}});
    assign reserve_hit_s = bus.reserve_enable && (bus.reserve_address != {AW{1'b0}});

    // Next-state for data and busy bits; a reserve overrides a release on the same register.
    always_comb begin
        regs_d[0] = {XLEN{1'b0}};
        busy_d    = {NREGS{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            if (write_hit_s && (bus.write_address == AW'(i))) begin
                regs_d[i] = bus.write_value;
            end else begin
                regs_d[i] = regs_q[i];
            end
            if (reserve_hit_s && (bus.reserve_address == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (write_hit_s && (bus.write_address == AW'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    // State registers; reset clears everything and discards the current cycle's updates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            busy_q <= {NREGS{1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Independent combinational read ports with optional writeback forwarding.
    always_comb begin
        read_value_s = {(NREAD*XLEN){1'b0}};
        read_busy_s  = {NREAD{1'b0}};
        for (int k = 0; k < NREAD; k++) begin
            port_addr_s[k] = bus.read_address[k*AW +: AW];
            if (port_addr_s[k] == {AW{1'b0}}) begin
                read_value_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
                read_busy_s[k]               = 1'b0;
            end else if ((BYPASS != 0) && reset_n && bus.write_enable &&
                         (port_addr_s[k] == bus.write_address)) begin
                read_value_s[k*XLEN +: XLEN] = bus.write_value;
                read_busy_s[k]               = 1'b0;
            end else begin
                read_value_s[k*XLEN +: XLEN] = regs_q[port_addr_s[k]];
                read_busy_s[k]               = busy_q[port_addr_s[k]];
            end
        end
    end

    assign bus.read_value = read_value_s;
    assign bus.read_busy  = read_busy_s;
    // Drain/fence indicator looks only at committed busy state.
    assign bus.any_busy   = |busy_q;

    regfile_scoreboard_chk #(
        .NREGS(NREGS)
    ) u_chk (
        .clock         (clock),
        .reset_n       (reset_n),
        .write_enable  (bus.write_enable),
        .write_address (bus.write_address),
        .busy          (busy_q)
    );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (bypass on/off) driven with the
// same stimulus and compared against an array-based model of the register file.
module tb_regfile_scoreboard;
    localparam int XLEN  = 64;
    localparam int NREGS = 16;
    localparam int NREAD = 3;
    localparam int AW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) if_byp ();
    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) if_nob ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dut_byp (
        .clock(clk), .reset_n(rst_n), .bus(if_byp));
    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dut_nob (
        .clock(clk), .reset_n(rst_n), .bus(if_nob));

    // Stimulus for the current cycle
    bit          t_we, t_re;
    int          t_wa, t_ra;
    logic [63:0] t_wv;
    int          t_rd [NREAD];

    // Reference model
    logic [63:0] m_regs [NREGS];
    bit          m_busy [NREGS];
    int          busy_list [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < NREGS; a++) begin
            m_regs[a] = 64'd0;
            m_busy[a] = 1'b0;
        end
    endtask

    function automatic logic [63:0] exp_val(input int a, input bit byp);
        if (!rst_n || a == 0) return 64'd0;
        if (byp && t_we && a == t_wa) return t_wv;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input int a, input bit byp);
        if (!rst_n || a == 0) return 1'b0;
        if (byp && t_we && a == t_wa) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic set_in(input bit we, input int wa, input logic [63:0] wv,
                          input bit re, input int ra, input int r0, input int r1, input int r2);
        t_we = we; t_wa = wa; t_wv = wv; t_re = re; t_ra = ra;
        t_rd[0] = r0; t_rd[1] = r1; t_rd[2] = r2;
    endtask

    task automatic apply();
        logic [NREAD*AW-1:0] ra_v;
        for (int k = 0; k < NREAD; k++) ra_v[k*AW +: AW] = AW'(t_rd[k]);
        if_byp.read_address = ra_v;         if_nob.read_address = ra_v;
        if_byp.write_enable = t_we;         if_nob.write_enable = t_we;
        if_byp.write_address = AW'(t_wa);   if_nob.write_address = AW'(t_wa);
        if_byp.write_value = t_wv;          if_nob.write_value = t_wv;
        if_byp.reserve_enable = t_re;       if_nob.reserve_enable = t_re;
        if_byp.reserve_address = AW'(t_ra); if_nob.reserve_address = AW'(t_ra);
    endtask

    task automatic check_outputs();
        bit any_exp = 1'b0;
        for (int a = 1; a < NREGS; a++) any_exp = any_exp | m_busy[a];
        for (int k = 0; k < NREAD; k++) begin
            check_eq($sformatf("byp_val_p%0d_x%0d", k, t_rd[k]), if_byp.read_value[k*XLEN +: XLEN], exp_val(t_rd[k], 1'b1));
            check_eq($sformatf("byp_busy_p%0d_x%0d", k, t_rd[k]), 64'(if_byp.read_busy[k]), 64'(exp_busy(t_rd[k], 1'b1)));
            check_eq($sformatf("nob_val_p%0d_x%0d", k, t_rd[k]), if_nob.read_value[k*XLEN +: XLEN], exp_val(t_rd[k], 1'b0));
            check_eq($sformatf("nob_busy_p%0d_x%0d", k, t_rd[k]), 64'(if_nob.read_busy[k]), 64'(exp_busy(t_rd[k], 1'b0)));
        end
        check_eq("byp_any_busy", 64'(if_byp.any_busy), 64'(any_exp));
        check_eq("nob_any_busy", 64'(if_nob.any_busy), 64'(any_exp));
    endtask

    task automatic drive_check();
        @(negedge clk);
        apply();
        #1;
        check_outputs();
    endtask

    task automatic commit();
        @(posedge clk);
        if (rst_n) begin
            if (t_we && t_wa != 0) begin
                m_regs[t_wa] = t_wv;
                m_busy[t_wa] = 1'b0;
            end
            if (t_re && t_ra != 0) m_busy[t_ra] = 1'b1;
        end
    endtask

    task automatic cycle();
        drive_check();
        commit();
    endtask

    // Pulse reset between edges; the pending cycle's updates must be discarded.
    task automatic rst_pulse();
        #1 rst_n = 1'b0;
        #1 model_clear();
        check_outputs();
        check_eq("rst_any_busy_async", 64'(if_byp.any_busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        set_in(1'b0, 0, 64'd0, 1'b0, 0, t_rd[0], t_rd[1], t_rd[2]);
        apply();
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        set_in(1'b0, 0, 64'd0, 1'b0, 0, 0, 0, 0);
        apply();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset and zero register
        set_in(1'b0, 0, 64'd0, 1'b1, 5, 5, 0, 0); cycle();
        set_in(1'b1, 5, 64'hDEADBEEF, 1'b0, 0, 5, 5, 0); cycle();
        set_in(1'b0, 0, 64'd0, 1'b0, 0, 5, 5, 0); drive_check();
        check_eq("x5_filled", if_nob.read_value[0 +: 64], 64'hDEADBEEF);
        rst_pulse();
        check_eq("x5_during_reset", if_byp.read_value[0 +: 64], 64'd0);
        set_in(1'b1, 0, 64'h12345678, 1'b0, 0, 0, 0, 0); cycle();
        set_in(1'b0, 0, 64'd0, 1'b0, 0, 0, 5, 0); drive_check();
        check_eq("x0_after_write", if_byp.read_value[0 +: 64], 64'd0);
        check_eq("x0_busy", 64'(if_byp.read_busy[0]), 64'd0);
        commit();

        // Same-cycle write and read of x7
        set_in(1'b0, 0, 64'd0, 1'b1, 7, 0, 0, 0); cycle();
        set_in(1'b1, 7, 64'hCAFEF00D, 1'b0, 0, 0, 7, 0); drive_check();
        check_eq("bypass_same_cycle", if_byp.read_value[64 +: 64], 64'hCAFEF00D);
        check_eq("nobypass_same_cycle", if_nob.read_value[64 +: 64], 64'd0);
        commit();
        set_in(1'b0, 0, 64'd0, 1'b0, 0, 0, 7, 0); drive_check();
        check_eq("nobypass_next_cycle", if_nob.read_value[64 +: 64], 64'hCAFEF00D);
        commit();

        // Scoreboard lifecycle on x3
        set_in(1'b0, 0, 64'd0, 1'b1, 3, 3, 3, 3); cycle();
        set_in(1'b1, 3, 64'h55, 1'b0, 0, 3, 3, 3); drive_check();
        check_eq("x3_busy_after_reserve", 64'(if_nob.read_busy[0]), 64'd1);
        check_eq("any_busy_after_reserve", 64'(if_byp.any_busy), 64'd1);
        commit();
        set_in(1'b0, 0, 64'd0, 1'b0, 0, 3, 3, 3); drive_check();
        check_eq("x3_released", 64'(if_nob.read_busy[1]), 64'd0);
        check_eq("x3_value", if_nob.read_value[128 +: 64], 64'h55);
        commit();

        // Write and reserve of x9 at the same edge
        set_in(1'b0, 0, 64'd0, 1'b1, 9, 9, 9, 9); cycle();
        set_in(1'b1, 9, 64'hA5A5A5A5, 1'b1, 9, 9, 9, 9); cycle();
        set_in(1'b0, 0, 64'd0, 1'b0, 0, 9, 9, 9); drive_check();
        check_eq("x9_value", if_byp.read_value[0 +: 64], 64'hA5A5A5A5);
        check_eq("x9_still_busy", 64'(if_byp.read_busy[0]), 64'd1);
        commit();

        // Multi-port reads
        set_in(1'b0, 0, 64'd0, 1'b1, 1, 0, 0, 0); cycle();
        set_in(1'b1, 1, 64'd1, 1'b1, 2, 0, 0, 0); cycle();
        set_in(1'b1, 2, 64'd2, 1'b1, 15, 0, 0, 0); cycle();
        set_in(1'b1, 15, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0, 0, 0, 0); cycle();
        set_in(1'b0, 0, 64'd0, 1'b0, 0, 15, 0, 2); drive_check();
        check_eq("mp_port0_x15", if_byp.read_value[0 +: 64], 64'hFFFFFFFFFFFFFFFF);
        check_eq("mp_port1_x0", if_byp.read_value[64 +: 64], 64'd0);
        check_eq("mp_port2_x2", if_byp.read_value[128 +: 64], 64'd2);
        commit();

        // Reset mid-operation with reservations held and one pending
        set_in(1'b0, 0, 64'd0, 1'b1, 4, 4, 6, 0); cycle();
        set_in(1'b0, 0, 64'd0, 1'b1, 6, 4, 6, 0); cycle();
        set_in(1'b0, 0, 64'd0, 1'b1, 4, 4, 6, 0); drive_check();
        rst_pulse();
        set_in(1'b0, 0, 64'd0, 1'b0, 0, 4, 6, 15); cycle();

        // Randomized traffic; writebacks only target reserved registers (or x0)
        for (int n = 0; n < 600; n++) begin
            busy_list.delete();
            for (int a = 1; a < NREGS; a++) if (m_busy[a]) busy_list.push_back(a);
            t_we = (busy_list.size() > 0) && ($urandom_range(0, 3) != 0);
            if (t_we) t_wa = busy_list[$urandom_range(0, busy_list.size() - 1)];
            else t_wa = int'($urandom_range(0, NREGS - 1));
            if (t_we && $urandom_range(0, 7) == 0) t_wa = 0;
            t_wv = {$urandom(), $urandom()};
            t_re = ($urandom_range(0, 1) == 1);
            t_ra = int'($urandom_range(0, NREGS - 1));
            for (int k = 0; k < NREAD; k++)
                t_rd[k] = ($urandom_range(0, 3) == 0) ? t_wa : int'($urandom_range(0, NREGS - 1));
            drive_check();
            if (n % 150 == 149) rst_pulse();
            else commit();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
